// File: rtl/csc_line_arbiter.sv
// Line-granular round-robin arbiter that shares one RGB->YCbCr converter between two pixel sources.
// Source tags ride a delay line matched to the converter latency so results are steered back per source.
module csc_line_arbiter #(
    parameter int unsigned CSC_LAT = 4,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        s0_valid_i,
    output logic        s0_ready_o,
    input  logic [23:0] s0_rgb_i,
    input  logic        s0_last_i,
    input  logic        s1_valid_i,
    output logic        s1_ready_o,
    input  logic [23:0] s1_rgb_i,
    input  logic        s1_last_i,
    output logic [23:0] csc_rgb_o,
    output logic        csc_en_o,
    input  logic [23:0] csc_ycbcr_i,
    output logic [23:0] m_ycbcr_o,
    output logic        m0_valid_o,
    output logic        m1_valid_o,
    output logic        m_last_o,
    output logic [1:0]  owner_o,
    output logic        err_timeout_o
);

    localparam int unsigned PIX_W = 24;
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    // State encoding doubles as the owner code (00 idle, 01 source 0, 10 source 1).
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_e;

    typedef struct packed {
        logic en;
        logic src;
        logic last;
    } tag_t;

    state_e             state_q;
    logic               last_owner_q;
    logic [CNT_W-1:0]   tmo_cnt_q;
    logic [CNT_W-1:0]   tmo_cnt_d;
    tag_t               tag_q [CSC_LAT];

    logic               hs;
    logic               src1;
    logic               sel_last;
    logic [PIX_W-1:0]   sel_rgb;

    assign s0_ready_o = (state_q == GNT0);
    assign s1_ready_o = (state_q == GNT1);
    assign owner_o    = state_q;
    assign m_ycbcr_o  = csc_ycbcr_i;

    assign src1     = (state_q == GNT1);
    assign hs       = (s0_valid_i & s0_ready_o) | (s1_valid_i & s1_ready_o);
    assign sel_last = src1 ? s1_last_i : s0_last_i;
    assign sel_rgb  = src1 ? s1_rgb_i : s0_rgb_i;

    // Idle-cycle counter saturates at the timeout threshold.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (tmo_cnt_q != TMO_LAST) begin
            tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end
    end

    // Line arbiter: whole lines are granted, ties go to the source that did not own the last line.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            last_owner_q  <= 1'b1;
            tmo_cnt_q     <= '0;
            err_timeout_o <= 1'b0;
        end else begin
            err_timeout_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    tmo_cnt_q <= '0;
                    if (s0_valid_i && (!s1_valid_i || last_owner_q)) begin
                        state_q <= GNT0;
                    end else if (s1_valid_i) begin
                        state_q <= GNT1;
                    end
                end
                GNT0, GNT1: begin
                    if (hs) begin
                        tmo_cnt_q <= '0;
                        if (sel_last) begin
                            state_q      <= IDLE;
                            last_owner_q <= src1;
                        end
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        err_timeout_o <= 1'b1;
                        state_q       <= IDLE;
                        last_owner_q  <= src1;
                        tmo_cnt_q     <= '0;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Converter feed and the source-tag delay line; final tag stage is registered onto the result valids.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            csc_rgb_o  <= '0;
            csc_en_o   <= 1'b0;
            m0_valid_o <= 1'b0;
            m1_valid_o <= 1'b0;
            m_last_o   <= 1'b0;
            for (int unsigned i = 0; i < CSC_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            csc_en_o <= hs;
            if (hs) begin
                csc_rgb_o <= sel_rgb;
            end
            tag_q[0] <= '{en: hs, src: src1, last: hs & sel_last};
            for (int unsigned i = 1; i < CSC_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            m0_valid_o <= tag_q[CSC_LAT-1].en & ~tag_q[CSC_LAT-1].src;
            m1_valid_o <= tag_q[CSC_LAT-1].en &  tag_q[CSC_LAT-1].src;
            m_last_o   <= tag_q[CSC_LAT-1].en &  tag_q[CSC_LAT-1].last;
        end
    end

endmodule

// File: tb/tb_csc_line_arbiter.sv
// Randomized scoreboard bench for csc_line_arbiter with a behavioural converter and per-source expectation queues.
module tb_csc_line_arbiter;

    localparam int unsigned LAT = 4;
    localparam int unsigned TMO = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s0_valid = 1'b0, s0_last = 1'b0, s1_valid = 1'b0, s1_last = 1'b0;
    logic [23:0] s0_rgb = '0, s1_rgb = '0;
    logic        s0_ready, s1_ready;
    logic [23:0] csc_rgb, csc_ycbcr, m_ycbcr;
    logic        csc_en, m0_valid, m1_valid, m_last, err_timeout;
    logic [1:0]  owner;

    typedef struct {
        logic [23:0] y;
        logic        last;
        int          cyc;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    int          grant_log[$];
    int          line_first_cyc[$];
    int          line_last_cyc[$];
    int          n_chk = 0, n_fail = 0, cyc = 0;
    int          err_cnt = 0, err_cyc = 0, en_cnt = 0, last_hs_cyc = 0;
    logic [23:0] fix_tbl [4];
    logic [23:0] sr [LAT];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    csc_line_arbiter #(.CSC_LAT(LAT), .TIMEOUT(TMO)) dut (
        .clk_i(clk), .rst_i(rst),
        .s0_valid_i(s0_valid), .s0_ready_o(s0_ready), .s0_rgb_i(s0_rgb), .s0_last_i(s0_last),
        .s1_valid_i(s1_valid), .s1_ready_o(s1_ready), .s1_rgb_i(s1_rgb), .s1_last_i(s1_last),
        .csc_rgb_o(csc_rgb), .csc_en_o(csc_en), .csc_ycbcr_i(csc_ycbcr),
        .m_ycbcr_o(m_ycbcr), .m0_valid_o(m0_valid), .m1_valid_o(m1_valid), .m_last_o(m_last),
        .owner_o(owner), .err_timeout_o(err_timeout)
    );

    function automatic logic [23:0] conv(input logic [23:0] p);
        return {p[15:8] ^ 8'h3C, p[7:0] ^ 8'hA5, p[23:16] ^ 8'h5A};
    endfunction

    // Behavioural converter: fixed latency, free running, unaffected by the arbiter reset.
    always @(posedge clk) begin
        for (int k = LAT - 1; k > 0; k--) sr[k] <= sr[k-1];
        sr[0] <= csc_rgb;
    end
    assign csc_ycbcr = conv(sr[LAT-1]);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic pop_check(input int s);
        exp_t e;
        int   sz;
        sz = (s == 0) ? q0.size() : q1.size();
        check((s == 0) ? "s0_result_pending" : "s1_result_pending", 32'(sz > 0), 1);
        if (sz > 0) begin
            if (s == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            check("result_data", m_ycbcr, e.y);
            check("result_last", 32'(m_last), 32'(e.last));
            check("result_latency", cyc, e.cyc);
        end
    endtask

    // Monitor: every result beat is matched against the head of its source queue.
    always @(negedge clk) begin
        if (csc_en) en_cnt++;
        if (err_timeout) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (!rst) begin
            if (m0_valid || m1_valid) check("m_valid_onehot", 32'(m0_valid) + 32'(m1_valid), 1);
            if (m0_valid) pop_check(0);
            if (m1_valid) pop_check(1);
        end
    end

    task automatic drive(input int s, input logic v, input logic [23:0] rgb, input logic l);
        if (s == 0) begin s0_valid = v; s0_rgb = rgb; s0_last = l; end
        else        begin s1_valid = v; s1_rgb = rgb; s1_last = l; end
    endtask

    task automatic send_line(input int s, input int n, input int maxgap, input bit fixed, input bit has_last);
        for (int i = 0; i < n; i++) begin
            int          gap;
            int          waited;
            bit          done;
            logic        lst;
            logic [23:0] px;
            exp_t        ent;
            gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
            if (gap > 0) begin
                drive(s, 1'b0, 24'h0, 1'b0);
                repeat (gap) @(posedge clk);
                #1;
            end
            px  = fixed ? fix_tbl[i] : 24'($urandom);
            lst = has_last && (i == n - 1);
            drive(s, 1'b1, px, lst);
            done = 0;
            waited = 0;
            while (!done) begin
                @(negedge clk);
                if (!rst && ((s == 0) ? s0_ready : s1_ready)) begin
                    done = 1;
                    ent.y = conv(px);
                    ent.last = lst;
                    ent.cyc = cyc + 1 + LAT;
                    if (s == 0) q0.push_back(ent);
                    else        q1.push_back(ent);
                    last_hs_cyc = cyc;
                    if (i == 0) begin
                        grant_log.push_back(s);
                        line_first_cyc.push_back(cyc);
                    end
                    if (lst) line_last_cyc.push_back(cyc);
                    check("owner_at_handshake", 32'(owner), s + 1);
                end else begin
                    waited++;
                    if (waited > 3000) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL grant_wait: source %0d not served after %0d cycles", s, waited);
                        drive(s, 1'b0, 24'h0, 1'b0);
                        return;
                    end
                end
            end
            @(posedge clk);
            #1;
        end
        drive(s, 1'b0, 24'h0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 1'b0, 24'h0, 1'b0);
        drive(1, 1'b0, 24'h0, 1'b0);
        q0.delete();
        q1.delete();
        grant_log.delete();
        line_first_cyc.delete();
        line_last_cyc.delete();
        @(negedge clk);
        check("rst_owner", 32'(owner), 0);
        check("rst_ready", {s0_ready, s1_ready}, 0);
        check("rst_csc", {csc_en, csc_rgb}, 0);
        check("rst_m", {m0_valid, m1_valid, m_last, err_timeout}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain();
        repeat (LAT + 4) @(negedge clk);
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0, n0;
        for (int k = 0; k < LAT; k++) sr[k] = '0;

        // Single source, fixed 4-pixel line.
        do_reset();
        fix_tbl[0] = 24'hFF0000; fix_tbl[1] = 24'h00FF00;
        fix_tbl[2] = 24'h0000FF; fix_tbl[3] = 24'hFFFFFF;
        n0 = en_cnt;
        send_line(0, 4, 0, 1, 1);
        @(negedge clk);
        check("t1_owner_after", 32'(owner), 0);
        drain();
        check("t1_csc_en_cycles", en_cnt - n0, 4);

        // Simultaneous requests from reset: s0 first, one idle cycle, then s1.
        do_reset();
        fork
            send_line(0, 2, 0, 0, 1);
            send_line(1, 2, 0, 0, 1);
        join
        drain();
        check("t2_order_len", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            check("t2_first", grant_log[0], 0);
            check("t2_second", grant_log[1], 1);
            check("t2_bubble", line_first_cyc[1], line_last_cyc[0] + 2);
        end

        // Persistent requests alternate line grants.
        do_reset();
        fork
            repeat (3) send_line(0, 2, 0, 0, 1);
            repeat (3) send_line(1, 3, 0, 0, 1);
        join
        drain();
        check("t3_order_len", grant_log.size(), 6);
        for (int i = 0; i < grant_log.size(); i++) check("t3_alternate", grant_log[i], i % 2);

        // Mid-line timeout on source 1.
        do_reset();
        e0 = err_cnt;
        send_line(1, 1, 0, 0, 0);
        repeat (TMO + LAT + 8) @(negedge clk);
        check("t4_err_pulses", err_cnt - e0, 1);
        check("t4_err_cycle", err_cyc, last_hs_cyc + TMO + 1);
        check("t4_owner", 32'(owner), 0);
        check("t4_queue_empty", q1.size(), 0);

        // Reset with a pixel in flight drops its result.
        do_reset();
        fix_tbl[0] = 24'h808080;
        send_line(0, 1, 0, 1, 0);
        @(posedge clk);
        #1;
        do_reset();
        for (int k = 0; k < LAT + 2; k++) begin
            @(negedge clk);
            check("t5_no_valid", {m0_valid, m1_valid}, 0);
        end
        check("t5_owner", 32'(owner), 0);
        check("t5_csc_en", 32'(csc_en), 0);

        // Stalling source below the timeout threshold.
        do_reset();
        e0 = err_cnt;
        send_line(0, 10, 1, 0, 1);
        drain();
        check("t6_no_err", err_cnt - e0, 0);

        // Randomized concurrent traffic.
        do_reset();
        e0 = err_cnt;
        fork
            for (int l = 0; l < 15; l++) begin
                int idle;
                send_line(0, int'($urandom_range(8, 1)), int'($urandom_range(3, 0)), 0, 1);
                idle = int'($urandom_range(4, 0));
                if (idle > 0) begin repeat (idle) @(posedge clk); #1; end
            end
            for (int l = 0; l < 15; l++) begin
                int idle;
                send_line(1, int'($urandom_range(8, 1)), int'($urandom_range(3, 0)), 0, 1);
                idle = int'($urandom_range(4, 0));
                if (idle > 0) begin repeat (idle) @(posedge clk); #1; end
            end
        join
        drain();
        check("rand_no_err", err_cnt - e0, 0);
        check("rand_lines", grant_log.size(), 30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
